// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: standard piece indices and LFSR constants.
package tetris_pkg;

  localparam int unsigned NUM_STD_PIECES    = 7;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;

  typedef enum logic [2:0] {
    PieceI = 3'd0,
    PieceO = 3'd1,
    PieceT = 3'd2,
    PieceS = 3'd3,
    PieceZ = 3'd4,
    PieceJ = 3'd5,
    PieceL = 3'd6
  } piece_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free-running after reset, with synchronous parallel load.
module lfsr16
  import tetris_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/piece_bag_queue.sv
// Bag-randomised piece source feeding a registered preview queue.
// Optional macro PIECE_SEED_LOAD_EN adds seed_load/seed ports for runtime reseeding.
module piece_bag_queue
  import tetris_pkg::*;
#(
  parameter int unsigned  NUM_PIECES = NUM_STD_PIECES,
  parameter int unsigned  NEXT_DEPTH = 3,
  parameter logic [15:0]  SEED       = LFSR_DEFAULT_SEED,
  localparam int unsigned PW         = $clog2(NUM_PIECES),
  localparam int unsigned CW         = $clog2(NEXT_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     take,
`ifdef PIECE_SEED_LOAD_EN
  input  logic                     seed_load,
  input  logic [15:0]              seed,
`endif
  output logic [PW-1:0]            piece,
  output logic                     valid,
  output logic [NEXT_DEPTH*PW-1:0] preview,
  output logic [CW-1:0]            count,
  output logic                     bag_wrap
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? LFSR_DEFAULT_SEED : SEED;
  localparam logic [PW:0] NP       = NUM_PIECES[PW:0];

  logic [15:0]                     lfsr;
  logic                            load;
  logic [15:0]                     load_val;
  logic [NEXT_DEPTH-1:0][PW-1:0]   q_q, q_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NUM_PIECES-1:0]           mask_q, mask_d, mask_set, sel_oh;
  logic                            valid_q, valid_d;
  logic                            wrap_q, wrap_d;
  logic [PW-1:0]                   cand, sel;
  logic                            found;
  logic                            do_take;
  int unsigned                     pos;
  logic                            unused_lfsr;

`ifdef PIECE_SEED_LOAD_EN
  assign load     = seed_load;
  assign load_val = (seed == 16'd0) ? LFSR_DEFAULT_SEED : seed;
`else
  assign load     = 1'b0;
  assign load_val = 16'd0;
`endif

  lfsr16 #(
    .RESET_VAL(SEED_EFF)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .q       (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:PW];

  // Candidate folded into range, then first free slot at or after it (wrapping).
  always_comb begin
    cand = lfsr[PW-1:0];
    if ({1'b0, cand} >= NP) cand = cand - NP[PW-1:0];
    sel   = cand;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_PIECES; k++) begin
      pos = 32'(cand) + k;
      if (pos >= NUM_PIECES) pos = pos - NUM_PIECES;
      if (!found && !mask_q[PW'(pos)]) begin
        sel   = PW'(pos);
        found = 1'b1;
      end
    end
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
    mask_set    = mask_q | sel_oh;
  end

  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    wrap_d  = 1'b0;
    do_take = take && valid_q;
    if (do_take) begin
      for (int unsigned i = 0; i < NEXT_DEPTH - 1; i++) q_d[i] = q_q[i+1];
      q_d[NEXT_DEPTH-1] = '0;
      cnt_d = cnt_q - 1'b1;
    end
    if (cnt_d < CW'(NEXT_DEPTH)) begin
      for (int unsigned i = 0; i < NEXT_DEPTH; i++) begin
        if (cnt_d == CW'(i)) q_d[i] = sel;
      end
      cnt_d = cnt_d + 1'b1;
      if (&mask_set) begin
        mask_d = '0;
        wrap_d = 1'b1;
      end else begin
        mask_d = mask_set;
      end
    end
`ifdef PIECE_SEED_LOAD_EN
    if (seed_load) begin
      q_d    = '0;
      cnt_d  = '0;
      mask_d = '0;
      wrap_d = 1'b0;
    end
`endif
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q     <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign piece    = q_q[0];
  assign valid    = valid_q;
  assign preview  = q_q;
  assign count    = cnt_q;
  assign bag_wrap = wrap_q;

endmodule

// File: tb/tb_piece_bag_queue.sv
// Bench for piece_bag_queue: depth-3 and depth-1 instances against a queue-based model.
module tb_piece_bag_queue;

  localparam int N = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       take3 = 1'b0, take1 = 1'b0;
  logic [2:0] piece3, piece1;
  logic       valid3, valid1;
  logic [8:0] prev3;
  logic [2:0] prev1;
  logic [1:0] cnt3;
  logic       cnt1;
  logic       wrap3, wrap1;
  bit         ld_v = 1'b0;
  logic [15:0] sd_v = 16'd0;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = depth 3, index 1 = depth 1
  int depth[2] = '{3, 1};
  int m_lfsr[2];
  int m_mask[2];
  int m_q[2][8];
  int m_cnt[2];
  int m_wrap[2];
  int grp_mask[2];
  int grp_n[2];
  int rec[3][30];

  always #5 clk = ~clk;

  piece_bag_queue #(.NEXT_DEPTH(3)) u_d3 (
    .clk     (clk),
    .rst     (rst),
    .take    (take3),
`ifdef PIECE_SEED_LOAD_EN
    .seed_load(ld_v),
    .seed    (sd_v),
`endif
    .piece   (piece3),
    .valid   (valid3),
    .preview (prev3),
    .count   (cnt3),
    .bag_wrap(wrap3)
  );

  piece_bag_queue #(.NEXT_DEPTH(1)) u_d1 (
    .clk     (clk),
    .rst     (rst),
    .take    (take1),
`ifdef PIECE_SEED_LOAD_EN
    .seed_load(ld_v),
    .seed    (sd_v),
`endif
    .piece   (piece1),
    .valid   (valid1),
    .preview (prev1),
    .count   (cnt1),
    .bag_wrap(wrap1)
  );

  function automatic int lfsr_adv(input int s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 32'hFFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int k, input int s);
    m_lfsr[k]   = s;
    m_mask[k]   = 0;
    m_cnt[k]    = 0;
    m_wrap[k]   = 0;
    grp_mask[k] = 0;
    grp_n[k]    = 0;
    for (int i = 0; i < 8; i++) m_q[k][i] = 0;
  endtask

  task automatic model_step(input int k, input bit tk, input bit ld, input int sd);
    int c;
    m_wrap[k] = 0;
    if (ld) begin
      model_clear(k, (sd == 0) ? 32'hACE1 : sd);
      return;
    end
    if (tk && m_cnt[k] > 0) begin
      for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
      m_q[k][7] = 0;
      m_cnt[k]--;
    end
    if (m_cnt[k] < depth[k]) begin
      c = m_lfsr[k] % 8;
      if (c >= N) c -= N;
      while (((m_mask[k] >> c) & 1) == 1) c = (c + 1) % N;
      m_q[k][m_cnt[k]] = c;
      m_cnt[k]++;
      m_mask[k] |= (1 << c);
      if (m_mask[k] == (1 << N) - 1) begin
        m_mask[k] = 0;
        m_wrap[k] = 1;
      end
    end
    m_lfsr[k] = lfsr_adv(m_lfsr[k]);
  endtask

  task automatic consume(input int k, input int p);
    grp_mask[k] |= (1 << p);
    grp_n[k]++;
    if (grp_n[k] == N) begin
      chk($sformatf("bag_perm%0d", k), grp_mask[k], 32'h7F);
      grp_mask[k] = 0;
      grp_n[k]    = 0;
    end
  endtask

  task automatic check_all(input string tag);
    int e3, e1;
    e3 = 0;
    e1 = 0;
    for (int i = 0; i < 3; i++) e3 |= m_q[0][i] << (i * 3);
    e1 = m_q[1][0];
    chk({tag, " piece3"}, piece3, m_q[0][0]);
    chk({tag, " valid3"}, valid3, m_cnt[0] > 0);
    chk({tag, " count3"}, cnt3, m_cnt[0]);
    chk({tag, " prev3"}, prev3, e3);
    chk({tag, " wrap3"}, wrap3, m_wrap[0]);
    chk({tag, " piece1"}, piece1, m_q[1][0]);
    chk({tag, " valid1"}, valid1, m_cnt[1] > 0);
    chk({tag, " count1"}, cnt1, m_cnt[1]);
    chk({tag, " prev1"}, prev1, e1);
    chk({tag, " wrap1"}, wrap1, m_wrap[1]);
  endtask

  task automatic step(input bit t3, input bit t1, input string tag);
    take3 = t3;
    take1 = t1;
    if (!ld_v && t3 && valid3) consume(0, int'(piece3));
    if (!ld_v && t1 && valid1) consume(1, int'(piece1));
    @(posedge clk);
    model_step(0, t3, ld_v, int'(sd_v));
    model_step(1, t1, ld_v, int'(sd_v));
    #1;
    check_all(tag);
  endtask

  task automatic run_pattern(input int p);
    step(0, 0, "fill1");
    chk("fill1 valid3", valid3, 1);
    chk("fill1 count3", cnt3, 1);
    chk("fill1 valid1", valid1, 1);
    step(0, 0, "fill2");
    chk("fill2 count3", cnt3, 2);
    step(0, 0, "fill3");
    chk("fill3 count3", cnt3, 3);
    step(0, 0, "hold");
    chk("hold count3", cnt3, 3);
    chk("hold wrap3", wrap3, 0);
    for (int i = 0; i < 30; i++) begin
      rec[p][i] = int'(piece3);
      step(1, 1, "pattern");
      chk("held valid1", valid1, 1);
    end
  endtask

  initial begin
    logic [2:0] b, c;
    int diff;
    model_clear(0, 32'hACE1);
    model_clear(1, 32'hACE1);
    #12;
    check_all("reset");
    rst = 1'b1;

    run_pattern(0);

    for (int i = 0; i < 70; i++) step(1, 1, "stream");

    step(0, 0, "prefill");
    b = prev3[5:3];
    c = prev3[8:6];
    step(1, 0, "single_take");
    chk("single piece=b", piece3, b);
    chk("single prev0=b", prev3[2:0], b);
    chk("single prev1=c", prev3[5:3], c);
    chk("single count", cnt3, 3);

    for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");

    step(0, 0, "pre_reset");
    #3;
    rst = 1'b0;
    #1;
    model_clear(0, 32'hACE1);
    model_clear(1, 32'hACE1);
    check_all("mid_reset");
    #2;
    rst = 1'b1;
    run_pattern(1);
    diff = 0;
    for (int i = 0; i < 30; i++) if (rec[1][i] != rec[0][i]) diff++;
    chk("replay_after_reset", diff, 0);

`ifdef PIECE_SEED_LOAD_EN
    for (int i = 0; i < 10; i++) step(1, 1, "pre_load");
    ld_v = 1'b1;
    sd_v = 16'd0;
    step(1, 1, "seed_load");
    chk("load count3", cnt3, 0);
    chk("load valid3", valid3, 0);
    ld_v = 1'b0;
    run_pattern(2);
    diff = 0;
    for (int i = 0; i < 30; i++) if (rec[2][i] != rec[0][i]) diff++;
    chk("replay_after_load", diff, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
